// File: rtl/fabric2_sarbiter.sv
// Two-master to one-slave OCP arbiter: round-robin grant held from command
// issue until the slave response completes, with a response watchdog.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

// state     | meaning
// ST_IDLE   | no grant; arbitrate between pending master requests
// ST_CMD    | granted command presented to slave, waiting for SCmdAccept
// ST_WAIT   | command accepted, waiting for slave response (watchdog runs)
module fabric2_sarbiter #(
  parameter int RESP_TIMEOUT = 255,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`ADDR_WIDTH-1:0]   i_M0_MAddr,
  input  logic [2:0]               i_M0_MCmd,
  input  logic [`DATA_WIDTH-1:0]   i_M0_MData,
  input  logic [`BEN_WIDTH-1:0]    i_M0_MByteEn,
  output logic                     o_M0_SCmdAccept,
  output logic [`DATA_WIDTH-1:0]   o_M0_SData,
  output logic [1:0]               o_M0_SResp,
  input  logic [`ADDR_WIDTH-1:0]   i_M1_MAddr,
  input  logic [2:0]               i_M1_MCmd,
  input  logic [`DATA_WIDTH-1:0]   i_M1_MData,
  input  logic [`BEN_WIDTH-1:0]    i_M1_MByteEn,
  output logic                     o_M1_SCmdAccept,
  output logic [`DATA_WIDTH-1:0]   o_M1_SData,
  output logic [1:0]               o_M1_SResp,
  output logic [`ADDR_WIDTH-1:0]   o_S_MAddr,
  output logic [2:0]               o_S_MCmd,
  output logic [`DATA_WIDTH-1:0]   o_S_MData,
  output logic [`BEN_WIDTH-1:0]    o_S_MByteEn,
  input  logic                     i_S_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0]   i_S_SData,
  input  logic [1:0]               i_S_SResp,
  output logic                     o_busy
);

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b11;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WAIT} state_t;

  state_t               state, state_n;
  logic                 gnt, gnt_n, last, last_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;

  logic [`ADDR_WIDTH-1:0] g_addr;
  logic [2:0]             g_cmd;
  logic [`DATA_WIDTH-1:0] g_data;
  logic [`BEN_WIDTH-1:0]  g_ben;
  logic                   req0, req1, slv_resp, timeout_hit;

  assign g_addr = gnt ? i_M1_MAddr   : i_M0_MAddr;
  assign g_cmd  = gnt ? i_M1_MCmd    : i_M0_MCmd;
  assign g_data = gnt ? i_M1_MData   : i_M0_MData;
  assign g_ben  = gnt ? i_M1_MByteEn : i_M0_MByteEn;

  assign req0        = (i_M0_MCmd != CMD_IDLE);
  assign req1        = (i_M1_MCmd != CMD_IDLE);
  assign slv_resp    = (i_S_SResp != RESP_NULL);
  assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt == TO_LAST);
  assign o_busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_n   = (req0 && req1) ? ~last : req1;
          state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        // a master withdrawing its command before accept is abandoned silently
        if (g_cmd == CMD_IDLE) begin
          state_n = ST_IDLE;
        end else if (i_S_SCmdAccept) begin
          cnt_n = '0;
          if (slv_resp) begin
            last_n  = gnt;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (slv_resp || timeout_hit) begin
          last_n  = gnt;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  logic                   acc_fwd;
  logic [1:0]             resp_fwd;
  logic [`DATA_WIDTH-1:0] data_fwd;

  always_comb begin
    o_S_MAddr   = '0;
    o_S_MCmd    = CMD_IDLE;
    o_S_MData   = '0;
    o_S_MByteEn = '0;
    acc_fwd     = 1'b0;
    resp_fwd    = RESP_NULL;
    data_fwd    = '0;
    case (state)
      ST_CMD: begin
        o_S_MAddr   = g_addr;
        o_S_MCmd    = g_cmd;
        o_S_MData   = g_data;
        o_S_MByteEn = g_ben;
        acc_fwd     = i_S_SCmdAccept;
        if (i_S_SCmdAccept && slv_resp) begin
          resp_fwd = i_S_SResp;
          data_fwd = i_S_SData;
        end
      end
      ST_WAIT: begin
        if (slv_resp) begin
          resp_fwd = i_S_SResp;
          data_fwd = i_S_SData;
        end else if (timeout_hit) begin
          resp_fwd = RESP_ERR;
        end
      end
      default: ;
    endcase
    o_M0_SCmdAccept = acc_fwd  & ~gnt;
    o_M0_SResp      = gnt ? RESP_NULL : resp_fwd;
    o_M0_SData      = gnt ? '0 : data_fwd;
    o_M1_SCmdAccept = acc_fwd  & gnt;
    o_M1_SResp      = gnt ? resp_fwd : RESP_NULL;
    o_M1_SData      = gnt ? data_fwd : '0;
  end

endmodule

// File: tb/tb_fabric2_sarbiter.sv
// Directed bench for fabric2_sarbiter: read path, round-robin, zero-wait
// back-to-back, watchdog timeout, stalled accept and mid-transaction reset.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif

module tb_fabric2_sarbiter;

  localparam logic [2:0] C_IDLE = 3'b000, C_WR = 3'b001, C_RD = 3'b010;
  localparam logic [1:0] R_NULL = 2'b00, R_DVA = 2'b01, R_ERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [`ADDR_WIDTH-1:0] m0_addr = '0, m1_addr = '0, s_maddr;
  logic [2:0]             m0_cmd = '0, m1_cmd = '0, s_mcmd;
  logic [`DATA_WIDTH-1:0] m0_data = '0, m1_data = '0, s_mdata, s_sdata = '0;
  logic [`DATA_WIDTH-1:0] m0_sdata, m1_sdata;
  logic [`BEN_WIDTH-1:0]  m0_ben = '0, m1_ben = '0, s_mben;
  logic                   m0_acc, m1_acc, s_acc = 1'b0, busy;
  logic [1:0]             m0_resp, m1_resp, s_resp = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fabric2_sarbiter #(.RESP_TIMEOUT(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_M0_MAddr(m0_addr), .i_M0_MCmd(m0_cmd), .i_M0_MData(m0_data), .i_M0_MByteEn(m0_ben),
    .o_M0_SCmdAccept(m0_acc), .o_M0_SData(m0_sdata), .o_M0_SResp(m0_resp),
    .i_M1_MAddr(m1_addr), .i_M1_MCmd(m1_cmd), .i_M1_MData(m1_data), .i_M1_MByteEn(m1_ben),
    .o_M1_SCmdAccept(m1_acc), .o_M1_SData(m1_sdata), .o_M1_SResp(m1_resp),
    .o_S_MAddr(s_maddr), .o_S_MCmd(s_mcmd), .o_S_MData(s_mdata), .o_S_MByteEn(s_mben),
    .i_S_SCmdAccept(s_acc), .i_S_SData(s_sdata), .i_S_SResp(s_resp),
    .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // advance to 1 ns after the next rising edge; inputs are driven there
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s_mcmd"}, s_mcmd, C_IDLE);
    chk({tag, ".s_maddr"}, s_maddr, '0);
    chk({tag, ".s_mdata"}, s_mdata, '0);
    chk({tag, ".s_mben"}, s_mben, '0);
    chk({tag, ".m0"}, {m0_acc, m0_resp, m0_sdata}, '0);
    chk({tag, ".m1"}, {m1_acc, m1_resp, m1_sdata}, '0);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_cmd = C_IDLE; m1_cmd = C_IDLE; s_acc = 1'b0; s_resp = R_NULL; s_sdata = '0;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    // reset values
    #3;
    chk_all_zero("reset");
    nxt();
    rst = 1'b0;

    // single M0 read, accept in CMD, DVA two cycles later
    m0_cmd = C_RD; m0_addr = 'h100; m0_ben = '1;
    #2;
    chk("rd.idle_mcmd", s_mcmd, C_IDLE);
    chk("rd.idle_busy", busy, 1'b0);
    nxt();
    s_acc = 1'b1;
    #2;
    chk("rd.cmd_mcmd", s_mcmd, C_RD);
    chk("rd.cmd_maddr", s_maddr, 'h100);
    chk("rd.cmd_acc", {m0_acc, m1_acc}, 2'b10);
    nxt();
    m0_cmd = C_IDLE; s_acc = 1'b0;
    #2;
    chk("rd.w1_mcmd", s_mcmd, C_IDLE);
    chk("rd.w1_busy", busy, 1'b1);
    chk("rd.w1_resp", m0_resp, R_NULL);
    nxt();
    s_resp = R_DVA; s_sdata = 'hDEADBEEF;
    #2;
    chk("rd.resp", m0_resp, R_DVA);
    chk("rd.data", m0_sdata, 'hDEADBEEF);
    chk("rd.m1_quiet", {m1_acc, m1_resp, m1_sdata}, '0);
    nxt();
    s_resp = R_NULL; s_sdata = '0;
    #2;
    chk("rd.after_resp", m0_resp, R_NULL);
    chk("rd.after_busy", busy, 1'b0);

    // both masters write continuously; zero-wait slave; grants alternate 0,1,...
    do_reset();
    m0_cmd = C_WR; m0_addr = 'h10; m0_data = 'hA0;
    m1_cmd = C_WR; m1_addr = 'h20; m1_data = 'hB1;
    s_acc = 1'b1; s_resp = R_DVA; s_sdata = 'h55;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("rr.idle_mcmd", s_mcmd, C_IDLE);
      chk("rr.idle_resp", {m0_resp, m1_resp}, 4'b0);
      nxt();
      #2;
      if (i % 2 == 0) begin
        chk("rr.addr0", s_maddr, 'h10);
        chk("rr.data0", s_mdata, 'hA0);
        chk("rr.acc0", {m0_acc, m1_acc}, 2'b10);
        chk("rr.resp0", {m0_resp, m1_resp}, {R_DVA, R_NULL});
      end else begin
        chk("rr.addr1", s_maddr, 'h20);
        chk("rr.data1", s_mdata, 'hB1);
        chk("rr.acc1", {m0_acc, m1_acc}, 2'b01);
        chk("rr.resp1", {m0_resp, m1_resp}, {R_NULL, R_DVA});
      end
      nxt();
    end

    // watchdog: accepted but never answered -> ERR on 4th wait cycle
    m1_cmd = C_IDLE; m0_addr = 'h300; s_resp = R_NULL; s_sdata = '0;
    nxt();
    #2;
    chk("to.cmd_mcmd", s_mcmd, C_WR);
    chk("to.cmd_maddr", s_maddr, 'h300);
    nxt();
    m0_cmd = C_IDLE; s_acc = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk("to.busy", busy, 1'b1);
      if (k < 4) chk("to.wait_resp", m0_resp, R_NULL);
      else begin
        chk("to.err", m0_resp, R_ERR);
        chk("to.err_data", m0_sdata, '0);
      end
      nxt();
    end
    s_resp = R_DVA; s_sdata = 'h1234;
    #2;
    chk("to.late_drop", {m0_resp, m0_sdata}, '0);
    chk("to.late_busy", busy, 1'b0);
    nxt();
    s_resp = R_NULL; s_sdata = '0;
    m0_cmd = C_RD; m0_addr = 'h500;
    nxt();
    s_acc = 1'b1; s_resp = R_DVA; s_sdata = 'hCAFE;
    #2;
    chk("to.next_addr", s_maddr, 'h500);
    chk("to.next_resp", m0_resp, R_DVA);
    chk("to.next_data", m0_sdata, 'hCAFE);
    nxt();

    // slave stalls SCmdAccept for 10 cycles
    m0_cmd = C_IDLE; s_acc = 1'b0; s_resp = R_NULL; s_sdata = '0;
    m1_cmd = C_WR; m1_addr = 'h600; m1_data = 'hAA;
    nxt();
    for (int k = 0; k < 10; k++) begin
      #2;
      chk("st.mcmd", s_mcmd, C_WR);
      chk("st.maddr", s_maddr, 'h600);
      chk("st.m1", {m1_acc, m1_resp}, '0);
      chk("st.busy", busy, 1'b1);
      nxt();
    end
    s_acc = 1'b1;
    #2;
    chk("st.acc", m1_acc, 1'b1);
    nxt();
    m1_cmd = C_IDLE; s_acc = 1'b0; s_resp = R_DVA; s_sdata = 'h77;
    #2;
    chk("st.resp", m1_resp, R_DVA);
    chk("st.data", m1_sdata, 'h77);
    nxt();
    s_resp = R_NULL; s_sdata = '0;

    // reset asserted while waiting for a response
    m0_cmd = C_RD; m0_addr = 'h700;
    nxt();
    s_acc = 1'b1;
    nxt();
    m0_cmd = C_IDLE; s_acc = 1'b0;
    #2;
    chk("rs.wait_busy", busy, 1'b1);
    s_resp = R_DVA; s_sdata = 'h99;
    rst = 1'b1;
    #1;
    chk_all_zero("rs.async");
    nxt();
    rst = 1'b0; s_resp = R_NULL; s_sdata = '0;
    m0_cmd = C_RD; m0_addr = 'h800;
    m1_cmd = C_RD; m1_addr = 'h900;
    nxt();
    #2;
    chk("rs.prio_addr", s_maddr, 'h800);
    chk("rs.prio_gnt", {m0_acc, m1_acc}, 2'b00);
    s_acc = 1'b1;
    #1;
    chk("rs.prio_acc", {m0_acc, m1_acc}, 2'b10);
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fabric2_sarbiter.md
Name: fabric2_sarbiter

Overview:
Two-master to one-slave OCP arbiter: the slave-side counterpart of the fabric master switch, placed in front of a shared slave (memory, peripheral bus).
- Round-robin arbitration between master ports M0 and M1.
- Grant is held from command issue until the slave's response completes.
- A response watchdog returns ERR to the master if the slave never responds.

Parameters:
RESP_TIMEOUT, 255, cycles allowed in WAIT_RESP before a forced ERR response; 0 disables the watchdog.
CNT_WIDTH, 8, width of the watchdog counter; must hold RESP_TIMEOUT.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_M0_MAddr  in  `ADDR_WIDTH  master 0 address
i_M0_MCmd  in  3  master 0 command
i_M0_MData  in  `DATA_WIDTH  master 0 write data
i_M0_MByteEn  in  `BEN_WIDTH  master 0 byte enables
o_M0_SCmdAccept  out  1  command accept to master 0
o_M0_SData  out  `DATA_WIDTH  read data to master 0
o_M0_SResp  out  2  response to master 0
i_M1_MAddr, i_M1_MCmd, i_M1_MData, i_M1_MByteEn  in  same widths as M0  master 1 request
o_M1_SCmdAccept, o_M1_SData, o_M1_SResp  out  same widths as M0  master 1 response
o_S_MAddr  out  `ADDR_WIDTH  address to slave
o_S_MCmd  out  3  command to slave
o_S_MData  out  `DATA_WIDTH  write data to slave
o_S_MByteEn  out  `BEN_WIDTH  byte enables to slave
i_S_SCmdAccept  in  1  slave command accept
i_S_SData  in  `DATA_WIDTH  slave read data
i_S_SResp  in  2  slave response
o_busy  out  1  high when state is not IDLE

Behaviour:
- Encodings follow ocp_const.vh: IDLE=000, WRITE=001, READ=010; NULL=00, DVA=01, ERR=11.
- Every command, read or write, gets exactly one non-NULL response cycle.
- Registered state: state{IDLE,CMD,WAIT_RESP}, gnt (0/1), last (last served master), cnt[CNT_WIDTH-1:0].
- Reset (async, rst=1): state=IDLE, gnt=0, last=1 (so M0 wins first), cnt=0.
- Reset values of all outputs: every o_* output 0 (MCmd=IDLE, SResp=NULL, SCmdAccept=0, o_busy=0).
- IDLE:
  - All slave outputs 0; both masters see SCmdAccept=0, SResp=NULL, SData=0.
  - Request = MCmd != IDLE.
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to ~last.
  - On a grant: gnt<=winner, state<=CMD.
  - Arbitration latency: 1 cycle from first request to the command appearing at the slave.
- CMD:
  - Slave outputs mirror granted master's MAddr/MCmd/MData/MByteEn combinationally.
  - o_Mg_SCmdAccept = i_S_SCmdAccept.
  - On accept: cnt<=0, state<=WAIT_RESP.
  - If i_S_SResp != NULL in the same cycle as accept: the response is forwarded that cycle, last<=gnt, state<=IDLE.
  - Granted master dropping MCmd to IDLE before accept is a protocol violation; state<=IDLE, no response.
- WAIT_RESP:
  - o_S_MCmd=IDLE; other slave outputs 0.
  - When i_S_SResp != NULL: forward SResp/SData to the granted master for that cycle, last<=gnt, state<=IDLE.
  - Otherwise cnt increments.
  - If RESP_TIMEOUT!=0 and cnt==RESP_TIMEOUT-1 with no response: drive ERR and SData=0 to the granted master for that cycle, last<=gnt, state<=IDLE.
  - A late slave response arriving after a timeout in IDLE is dropped.
- Non-granted master always sees SCmdAccept=0, SResp=NULL, SData=0.
- A request held by the loser is not lost; it is served in a later IDLE cycle.
- With both masters continuously requesting, grants alternate 0,1,0,1.
- Back-to-back: IDLE occupies one cycle between transactions, so minimum transaction spacing is 2 cycles for zero-wait slaves.
- o_busy = (state != IDLE).
- Reset mid-transaction: immediate return to reset state; no response is issued.

Test Plan:
- Single M0 READ 0x100, slave accepts on cycle 1 and returns DVA with 0xDEADBEEF on cycle 3 -> slave sees MCmd=READ only in CMD, o_M0_SResp=DVA with 0xDEADBEEF for exactly 1 cycle; M1 outputs stay 0.
- M0 and M1 both issue WRITE in the same cycle after reset -> M0 served first, then M1; with 4 continuous requests each, grant order is 0,1,0,1,…
- Slave accepts and responds DVA in the same cycle -> returns to IDLE next cycle, next request reaches the slave 2 cycles after the previous one.
- RESP_TIMEOUT=4, slave accepts but never responds -> ERR on master on 4th WAIT_RESP cycle; a DVA arriving later is dropped; next request is served normally.
- Slave holds SCmdAccept=0 for 10 cycles -> slave MCmd/MAddr remain stable, no timeout (watchdog counts only in WAIT_RESP), accept on cycle 11 proceeds normally.
- rst asserted in WAIT_RESP -> all outputs 0 asynchronously, o_busy=0; after release, M0 has priority.
